// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and byte payload for the LCD screen sequencer.
package lcd_pkg;

  localparam int unsigned CNT_W     = 20;
  localparam int unsigned STEP_W    = 6;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BUF_DEPTH = 32;

  localparam logic [DATA_W-1:0] LCD_FUNC_SET = 8'h38;
  localparam logic [DATA_W-1:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [DATA_W-1:0] LCD_CLEAR    = 8'h01;
  localparam logic [DATA_W-1:0] LCD_ENTRY    = 8'h06;
  localparam logic [DATA_W-1:0] LCD_LINE1    = 8'h80;
  localparam logic [DATA_W-1:0] LCD_LINE2    = 8'hC0;
  localparam logic [DATA_W-1:0] LCD_SPACE    = 8'h20;

  localparam logic [STEP_W-1:0] STEP_FIRST     = 6'd0;
  localparam logic [STEP_W-1:0] STEP_CLEAR     = 6'd2;
  localparam logic [STEP_W-1:0] STEP_LINE1     = 6'd4;
  localparam logic [STEP_W-1:0] STEP_LINE1_END = 6'd20;
  localparam logic [STEP_W-1:0] STEP_LINE2     = 6'd21;
  localparam logic [STEP_W-1:0] STEP_LAST      = 6'd37;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_LOAD,
    ST_START,
    ST_ACK_LOW,
    ST_ACK_HIGH,
    ST_GAP,
    ST_IDLE
  } seq_state_t;

  typedef struct packed {
    logic              rs;
    logic [DATA_W-1:0] data;
  } lcd_byte_t;

  // Down-counter preload that makes a wait of N cycles last N (minimum 1) cycles.
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
    return (cycles == 0) ? '0 : CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/lcd_char_buffer.sv
// 32-byte screen image with synchronous write, asynchronous read and a refresh-pending flag.
module lcd_char_buffer
  import lcd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              clr_dirty,
  output logic [DATA_W-1:0] rd_data_c,
  output logic              dirty
);

  logic [DATA_W-1:0] mem [BUF_DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) mem[i] <= LCD_SPACE;
    end else if (wr) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // A write in the same cycle as the clear wins, so no update is ever lost.
  always_ff @(posedge clk) begin
    if (!rst_n)         dirty <= 1'b0;
    else if (wr)        dirty <= 1'b1;
    else if (clr_dirty) dirty <= 1'b0;
  end

  assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/lcd_screen_sequencer.sv
// Runs the HD44780 init sequence, then streams the 2x16 screen image to the byte writer.
module lcd_screen_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES   = 750000,
  parameter int unsigned CMD_GAP_CYCLES   = 2000,
  parameter int unsigned CLEAR_GAP_CYCLES = 82000
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iWR,
  input  logic [ADDR_W-1:0] iADDR,
  input  logic [DATA_W-1:0] iCHAR,
  output logic              oBusy,
  output logic [DATA_W-1:0] oLCD_DATA,
  output logic              oLCD_RS,
  output logic              oLCD_START,
  input  logic              iLCD_DONE
);

  localparam logic [CNT_W-1:0] PWR_LOAD   = cnt_load(POWERUP_CYCLES);
  localparam logic [CNT_W-1:0] CMD_LOAD   = cnt_load(CMD_GAP_CYCLES);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = cnt_load(CLEAR_GAP_CYCLES);

  seq_state_t        state, state_nxt;
  logic [STEP_W-1:0] step, step_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              rs_nxt, start_nxt, busy_nxt;
  logic              clr_dirty_c, dirty;
  logic [ADDR_W-1:0] rd_addr_c;
  logic [DATA_W-1:0] rd_data_c;
  logic [STEP_W-1:0] rd_ofs_c;
  lcd_byte_t         cur_c;

  lcd_char_buffer u_buf (
    .clk       (iCLK),
    .rst_n     (iRST_N),
    .wr        (iWR),
    .wr_addr   (iADDR),
    .wr_data   (iCHAR),
    .rd_addr   (rd_addr_c),
    .clr_dirty (clr_dirty_c),
    .rd_data_c (rd_data_c),
    .dirty     (dirty)
  );

  // Line 1 characters sit at steps 5..20, line 2 at steps 22..37.
  always_comb begin
    rd_ofs_c  = (step <= STEP_LINE1_END) ? STEP_W'(5) : STEP_W'(6);
    rd_addr_c = ADDR_W'(step - rd_ofs_c);
  end

  always_comb begin
    cur_c = '{rs: 1'b1, data: rd_data_c};
    case (step)
      6'd0:       cur_c = '{rs: 1'b0, data: LCD_FUNC_SET};
      6'd1:       cur_c = '{rs: 1'b0, data: LCD_DISP_ON};
      6'd2:       cur_c = '{rs: 1'b0, data: LCD_CLEAR};
      6'd3:       cur_c = '{rs: 1'b0, data: LCD_ENTRY};
      STEP_LINE1: cur_c = '{rs: 1'b0, data: LCD_LINE1};
      STEP_LINE2: cur_c = '{rs: 1'b0, data: LCD_LINE2};
      default:    cur_c = '{rs: 1'b1, data: rd_data_c};
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state      <= ST_POWERUP;
      step       <= STEP_FIRST;
      cnt        <= PWR_LOAD;
      oLCD_DATA  <= '0;
      oLCD_RS    <= 1'b0;
      oLCD_START <= 1'b0;
      oBusy      <= 1'b1;
    end else begin
      state      <= state_nxt;
      step       <= step_nxt;
      cnt        <= cnt_nxt;
      oLCD_DATA  <= data_nxt;
      oLCD_RS    <= rs_nxt;
      oLCD_START <= start_nxt;
      oBusy      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    step_nxt    = step;
    cnt_nxt     = cnt;
    data_nxt    = oLCD_DATA;
    rs_nxt      = oLCD_RS;
    start_nxt   = oLCD_START;
    clr_dirty_c = 1'b0;

    case (state)
      ST_POWERUP: begin
        if (cnt == '0) begin
          state_nxt = ST_LOAD;
          step_nxt  = STEP_FIRST;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_LOAD: begin
        data_nxt  = cur_c.data;
        rs_nxt    = cur_c.rs;
        state_nxt = ST_START;
      end
      ST_START: begin
        start_nxt = 1'b1;
        state_nxt = ST_ACK_LOW;
      end
      ST_ACK_LOW: begin
        if (!iLCD_DONE) state_nxt = ST_ACK_HIGH;
      end
      ST_ACK_HIGH: begin
        if (iLCD_DONE) begin
          start_nxt = 1'b0;
          cnt_nxt   = (step == STEP_CLEAR) ? CLEAR_LOAD : CMD_LOAD;
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else if (step == STEP_LAST) begin
          state_nxt = ST_IDLE;
        end else begin
          step_nxt  = step + STEP_W'(1);
          state_nxt = ST_LOAD;
        end
      end
      ST_IDLE: begin
        if (dirty) begin
          clr_dirty_c = 1'b1;
          step_nxt    = STEP_LINE1;
          state_nxt   = ST_LOAD;
        end
      end
      default: state_nxt = ST_POWERUP;
    endcase

    // Mirrors the buffer's dirty update so busy tracks it without a cycle of lag.
    busy_nxt = (state_nxt != ST_IDLE) | iWR | (dirty & ~clr_dirty_c);
  end

endmodule

// File: tb/tb_lcd_screen_sequencer.sv
// Scoreboard bench for lcd_screen_sequencer with a behavioural byte writer.
module tb_lcd_screen_sequencer;

  localparam int unsigned P_PWR = 5;
  localparam int unsigned P_CMD = 3;
  localparam int unsigned P_CLR = 7;
  localparam int unsigned D     = 4;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
    logic [7:0] gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, wr;
  logic [4:0] addr;
  logic [7:0] chr;
  logic       busy, rs, start;
  logic [7:0] data;
  logic       done = 1'b1;
  logic       hold_done = 1'b0;

  exp_t       q[$];
  exp_t       e;
  int         total = 0;
  int         bad = 0;
  int         n_starts = 0;
  int         low_cnt = 0;
  int         base;
  logic       prev_start = 1'b0;
  logic       start_d = 1'b0;
  int         wcnt = 0;
  logic [7:0] model_buf [32];

  always #5 clk = ~clk;

  lcd_screen_sequencer #(
    .POWERUP_CYCLES   (P_PWR),
    .CMD_GAP_CYCLES   (P_CMD),
    .CLEAR_GAP_CYCLES (P_CLR)
  ) dut (
    .iCLK       (clk),
    .iRST_N     (rst_n),
    .iWR        (wr),
    .iADDR      (addr),
    .iCHAR      (chr),
    .oBusy      (busy),
    .oLCD_DATA  (data),
    .oLCD_RS    (rs),
    .oLCD_START (start),
    .iLCD_DONE  (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Writer: drops done on a start rising edge, raises it D cycles later.
  always @(posedge clk) begin
    start_d <= start;
    if (hold_done) begin
      done <= 1'b1;
    end else if (start && !start_d) begin
      done <= 1'b0;
      wcnt <= D;
    end else if (!done) begin
      if (wcnt <= 1) done <= 1'b1;
      else           wcnt <= wcnt - 1;
    end
  end

  // Monitor: every start rising edge pops one expected byte; the low time before it is the gap+LOAD+START.
  always @(negedge clk) begin
    if (start && !prev_start) begin
      n_starts++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_start: got rs=%0b data=%0h expected no transfer", rs, data);
      end else begin
        e = q.pop_front();
        check("byte", 32'({rs, data}), 32'({e.rs, e.data}));
        if (e.gap != 8'hFF) check("gap", 32'(low_cnt), 32'(e.gap));
      end
      low_cnt = 0;
    end else if (!start) begin
      low_cnt++;
    end
    prev_start = start;
  end

  task automatic push_pass(input bit full);
    logic [7:0] cmds [4];
    exp_t       x;
    int         first;
    cmds  = '{8'h38, 8'h0C, 8'h01, 8'h06};
    first = full ? 0 : 4;
    for (int s = first; s <= 37; s++) begin
      if (s == first)  x.gap = 8'hFF;
      else if (s == 3) x.gap = 8'(P_CLR + 2);
      else             x.gap = 8'(P_CMD + 2);
      if (s < 4)       begin x.rs = 1'b0; x.data = cmds[s]; end
      else if (s == 4) begin x.rs = 1'b0; x.data = 8'h80; end
      else if (s < 21) begin x.rs = 1'b1; x.data = model_buf[s-5]; end
      else if (s == 21) begin x.rs = 1'b0; x.data = 8'hC0; end
      else             begin x.rs = 1'b1; x.data = model_buf[s-6]; end
      q.push_back(x);
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] c);
    wr   = 1'b1;
    addr = a;
    chr  = c;
    model_buf[a] = c;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 5000; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_starts(input int n, input string name);
    for (int i = 0; i < 3000; i++) begin
      if (n_starts >= n) break;
      @(negedge clk);
    end
    check(name, 32'(n_starts >= n), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_data"},  32'(data),  32'h00);
    check({tag, "_rs"},    32'(rs),    32'd0);
    check({tag, "_start"}, 32'(start), 32'd0);
    check({tag, "_busy"},  32'(busy),  32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    wr    = 1'b0;
    addr  = '0;
    chr   = '0;
    for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
    repeat (3) @(negedge clk);
    check_reset("rst");

    // Power-on init plus the first all-spaces screen.
    push_pass(1'b1);
    rst_n = 1'b1;
    wait_idle("init_idle");
    check("init_starts", 32'(n_starts), 32'd38);

    // Single character on line 2 triggers one 34-byte refresh.
    base = n_starts;
    do_write(5'd17, 8'h41);
    check("busy_after_wr", 32'(busy), 32'd1);
    push_pass(1'b0);
    wait_idle("refresh_idle");
    check("refresh_starts", 32'(n_starts - base), 32'd34);

    // Write to an already-sent position mid-refresh: old value now, new value on the re-pass.
    base = n_starts;
    do_write(5'd5, 8'h42);
    push_pass(1'b0);
    wait_starts(base + 7, "reach_step10");
    do_write(5'd3, 8'h5A);
    check("busy_mid_refresh", 32'(busy), 32'd1);
    push_pass(1'b0);
    wait_idle("repass_idle");
    check("repass_starts", 32'(n_starts - base), 32'd68);

    // Quiet screen: no traffic.
    base = n_starts;
    repeat (10000) @(negedge clk);
    check("quiet_starts", 32'(n_starts - base), 32'd0);
    check("quiet_busy", 32'(busy), 32'd0);

    // Reset at step 25 aborts, restores spaces and reruns init.
    base = n_starts;
    do_write(5'd0, 8'h33);
    push_pass(1'b0);
    wait_starts(base + 22, "reach_step25");
    rst_n = 1'b0;
    q.delete();
    for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
    @(negedge clk);
    check_reset("midrst");
    rst_n = 1'b1;
    base = n_starts;
    push_pass(1'b1);
    wait_idle("reinit_idle");
    check("reinit_starts", 32'(n_starts - base), 32'd38);

    // Writer never drops done: sequencer parks with start held high.
    hold_done = 1'b1;
    base = n_starts;
    do_write(5'd1, 8'h44);
    q.push_back('{rs: 1'b0, data: 8'h80, gap: 8'hFF});
    repeat (60) @(negedge clk);
    check("stall_start", 32'(start), 32'd1);
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_starts", 32'(n_starts - base), 32'd1);
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
